// File: rtl/mcac_pkg.sv
// Shared definitions for the MCAC predictor: FSM states, default term counts
// and the FMULT term-index encoding steered by the sequencer.
package mcac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mcac_state_e;

    localparam int MCAC_NB = 6;
    localparam int MCAC_NA = 2;
    localparam int MCAC_PW = 16;

    // Term index driven onto the FMULT operand muxes.
    localparam logic [2:0] SEL_B1 = 3'd0;
    localparam logic [2:0] SEL_B2 = 3'd1;
    localparam logic [2:0] SEL_B3 = 3'd2;
    localparam logic [2:0] SEL_B4 = 3'd3;
    localparam logic [2:0] SEL_B5 = 3'd4;
    localparam logic [2:0] SEL_B6 = 3'd5;
    localparam logic [2:0] SEL_A1 = 3'd6;
    localparam logic [2:0] SEL_A2 = 3'd7;

endpackage

// File: rtl/fmult_accum_ctrl.sv
// Sequencer for the time-shared FMULT: issues the B then A term indices,
// accumulates the returned products and publishes SEZ and SE.
module fmult_accum_ctrl
    import mcac_pkg::*;
#(
    parameter int NB        = MCAC_NB,
    parameter int NA        = MCAC_NA,
    parameter int PW        = MCAC_PW,
    parameter int FMULT_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [2:0]    sel,
    output logic          sel_vld,
    input  logic [PW-1:0] prod,
    output logic          busy,
    output logic          done,
    output logic [PW-2:0] sez,
    output logic [PW-2:0] se,
    input  logic          scan_in0,
    input  logic          scan_en,
    output logic          scan_out0
);

    localparam int         NT        = NB + NA;
    localparam logic [2:0] SEL_LAST  = 3'(NT - 1);
    localparam logic [3:0] CNT_ZLAST = 4'(NB - 1);
    localparam logic [3:0] CNT_LAST  = 4'(NT - 1);

    mcac_state_e            state_q;
    logic [2:0]             sel_q;
    logic                   sel_vld_q;
    logic                   busy_q;
    logic                   done_q;
    logic [PW-2:0]          sez_q;
    logic [PW-2:0]          se_q;
    logic [PW-1:0]          acc_q;
    logic [PW-1:0]          sezi_q;
    logic [3:0]             cnt_q;
    logic [FMULT_LAT-1:0]   vld_pipe_q;

    logic [FMULT_LAT:0]     vld_chain_d;
    logic                   prod_vld;
    logic [PW-1:0]          acc_d;
    logic                   launch;
    logic                   unused_scan;

    // The valid pipeline mirrors the FMULT latency so each product is
    // accepted exactly in the cycle it is returned.
    assign vld_chain_d = {vld_pipe_q, sel_vld_q};
    assign prod_vld    = vld_pipe_q[FMULT_LAT-1];
    assign acc_d       = acc_q + prod;
    assign launch      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= 3'd0;
            sel_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sez_q      <= '0;
            se_q       <= '0;
            acc_q      <= '0;
            sezi_q     <= '0;
            cnt_q      <= 4'd0;
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_chain_d[FMULT_LAT-1:0];
            done_q     <= 1'b0;

            if (prod_vld) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == CNT_ZLAST) begin
                    sezi_q <= acc_d;
                end
            end

            if (launch) begin
                // No product can be in flight in IDLE or DONE, so clearing
                // the accumulator here never drops a live term.
                state_q   <= ST_ISSUE;
                sel_q     <= SEL_B1;
                sel_vld_q <= 1'b1;
                busy_q    <= 1'b1;
                acc_q     <= '0;
                cnt_q     <= 4'd0;
            end else begin
                case (state_q)
                    ST_ISSUE: begin
                        if (sel_q == SEL_LAST) begin
                            state_q   <= ST_DRAIN;
                            sel_q     <= 3'd0;
                            sel_vld_q <= 1'b0;
                        end else begin
                            sel_q <= sel_q + 3'd1;
                        end
                    end
                    ST_DRAIN: begin
                        if (prod_vld && (cnt_q == CNT_LAST)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sez_q   <= sezi_q[PW-1:1];
                            se_q    <= acc_d[PW-1:1];
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sel       = sel_q;
    assign sel_vld   = sel_vld_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sez       = sez_q;
    assign se        = se_q;
    assign scan_out0 = 1'b0;

    // Scan pins are stitched at scan insertion; nothing functional here.
    assign unused_scan = ^{scan_in0, scan_en};

endmodule
